// File: rtl/d_branch_ctrl.sv
// d_branch_ctrl: decode-stage branch resolve with hazard hold, timeout flag and statistics
module d_branch_ctrl #(
  parameter int MAX_WAIT = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      D_instr,
  input  logic [31:0]      D_pc4,
  input  logic             D_valid,
  input  logic [31:0]      D_rs_val,
  input  logic [31:0]      D_rt_val,
  input  logic [4:0]       E_wa,
  input  logic [1:0]       E_Tnew,
  input  logic [4:0]       M_wa,
  input  logic [1:0]       M_Tnew,
  input  logic             ext_stall,
  output logic             stall_D,
  output logic             npc_sel,
  output logic [31:0]      branch_target,
  output logic             err_timeout,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WW = $clog2(MAX_WAIT + 2);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [5:0] op;
  logic [4:0] rs, rt;
  logic beq, bne, bgtz, blez, bgez, bltz, is_br, cond, haz_rs, haz_rt, haz, resolve;
  always_comb begin
    op = D_instr[31:26];
    rs = D_instr[25:21];
    rt = D_instr[20:16];
    beq = op == 6'b000100;
    bne = op == 6'b000101;
    bgtz = op == 6'b000111;
    blez = op == 6'b000110;
    bgez = op == 6'b000001 && rt == 5'b00001;
    bltz = op == 6'b000001 && rt == 5'b00000;
    is_br = D_valid & (beq | bne | bgtz | blez | bgez | bltz);
    haz_rs = |rs & ((rs == E_wa & |E_Tnew) | (rs == M_wa & |M_Tnew));
    haz_rt = (beq | bne) & |rt & ((rt == E_wa & |E_Tnew) | (rt == M_wa & |M_Tnew));
    haz = is_br & (haz_rs | haz_rt);
    cond = beq ? D_rs_val == D_rt_val :
           bne ? D_rs_val != D_rt_val :
           bgez ? !D_rs_val[31] :
           bltz ? D_rs_val[31] :
           bgtz ? !D_rs_val[31] & |D_rs_val :
           D_rs_val[31] | ~|D_rs_val;
    resolve = is_br & !haz & !ext_stall;
    stall_D = haz;
    npc_sel = resolve & cond;
    branch_target = D_pc4 + {{14{D_instr[15]}}, D_instr[15:0], 2'b00};
    wcnt_n = !haz ? '0 :
             state == IDLE ? WW'(1) :
             wcnt == WW'(MAX_WAIT + 1) ? wcnt : wcnt + WW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      err_timeout <= 1'b0;
      br_cnt <= '0;
      taken_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= haz ? HOLD : IDLE;
      wcnt <= wcnt_n;
      if (wcnt_n > WW'(MAX_WAIT)) err_timeout <= 1'b1;
      stall_cnt <= stall_cnt + CNT_W'(haz);
      br_cnt <= br_cnt + CNT_W'(resolve);
      taken_cnt <= taken_cnt + CNT_W'(npc_sel);
    end
  end
endmodule

// File: tb/tb_d_branch_ctrl.sv
// tb_d_branch_ctrl: directed and random checks of d_branch_ctrl against a behavioural model
module tb_d_branch_ctrl;
  localparam int MW = 3;
  logic clk = 1'b0, reset;
  logic [31:0] D_instr, D_pc4, D_rs_val, D_rt_val, branch_target, br_cnt, taken_cnt, stall_cnt;
  logic D_valid, ext_stall, stall_D, npc_sel, err_timeout;
  logic [4:0] E_wa, M_wa;
  logic [1:0] E_Tnew, M_Tnew;
  int tests = 0, fails = 0;
  int m_run = 0;
  logic m_err = 1'b0;
  logic [31:0] m_br = '0, m_tk = '0, m_st = '0;
  d_branch_ctrl #(.MAX_WAIT(MW), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .D_instr(D_instr), .D_pc4(D_pc4), .D_valid(D_valid),
    .D_rs_val(D_rs_val), .D_rt_val(D_rt_val), .E_wa(E_wa), .E_Tnew(E_Tnew),
    .M_wa(M_wa), .M_Tnew(M_Tnew), .ext_stall(ext_stall), .stall_D(stall_D),
    .npc_sel(npc_sel), .branch_target(branch_target), .err_timeout(err_timeout),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input int op, input int s, input int t, input int imm);
    mk = {6'(op), 5'(s), 5'(t), 16'(imm)};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [31:0] ins, input logic [31:0] pc4, input logic v,
                      input logic [31:0] a, input logic [31:0] b,
                      input int ew, input int et, input int mw, input int mt,
                      input logic es, input logic rst);
    int op, s, t, imm;
    logic br, two, c, isb, hz, npc;
    logic [31:0] tgt;
    D_instr = ins; D_pc4 = pc4; D_valid = v; D_rs_val = a; D_rt_val = b;
    E_wa = 5'(ew); E_Tnew = 2'(et); M_wa = 5'(mw); M_Tnew = 2'(mt);
    ext_stall = es; reset = rst;
    op = int'(ins[31:26]); s = int'(ins[25:21]); t = int'(ins[20:16]);
    imm = int'($signed(ins[15:0]));
    br = 0; two = 0; c = 0;
    if (op == 4) begin br = 1; two = 1; c = a == b; end
    else if (op == 5) begin br = 1; two = 1; c = a != b; end
    else if (op == 7) begin br = 1; c = $signed(a) > 0; end
    else if (op == 6) begin br = 1; c = $signed(a) <= 0; end
    else if (op == 1 && t == 1) begin br = 1; c = $signed(a) >= 0; end
    else if (op == 1 && t == 0) begin br = 1; c = $signed(a) < 0; end
    isb = v & br;
    hz = isb & ((s != 0 && ((s == ew && et != 0) || (s == mw && mt != 0))) ||
                (two && t != 0 && ((t == ew && et != 0) || (t == mw && mt != 0))));
    npc = isb & !hz & !es & c;
    tgt = pc4 + 32'(imm * 4);
    #1;
    chk("stall_D", 32'(stall_D), 32'(hz));
    chk("npc_sel", 32'(npc_sel), 32'(npc));
    chk("branch_target", branch_target, tgt);
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_err = 0; m_br = 0; m_tk = 0; m_st = 0;
    end else begin
      m_run = hz ? m_run + 1 : 0;
      if (m_run > MW) m_err = 1;
      if (hz) m_st++;
      if (isb && !hz && !es) m_br++;
      if (npc) m_tk++;
    end
    #1;
    chk("err_timeout", 32'(err_timeout), 32'(m_err));
    chk("br_cnt", br_cnt, m_br);
    chk("taken_cnt", taken_cnt, m_tk);
    chk("stall_cnt", stall_cnt, m_st);
  endtask
  task automatic rst_step();
    step(32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 1'b0, 1'b1);
  endtask
  initial begin
    logic [31:0] vals [7] = '{32'h0, 32'h1, 32'h5, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h0};
    int ops [9] = '{4, 5, 6, 7, 1, 1, 0, 8, 35};
    rst_step();
    chk("reset_br", br_cnt, 32'h0);
    chk("reset_err", 32'(err_timeout), 32'h0);
    step(mk(4, 1, 2, 3), 32'h3004, 1, 5, 5, 0, 0, 0, 0, 0, 0);
    chk("t1_target", branch_target, 32'h3010);
    chk("t1_br", br_cnt, 32'd1);
    chk("t1_taken", taken_cnt, 32'd1);
    step(mk(5, 1, 2, 16'hFFFF), 32'h100, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
    step(mk(1, 1, 0, 8), 32'h200, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0);
    step(mk(6, 1, 0, 8), 32'h200, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(mk(7, 1, 0, 8), 32'h200, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(mk(1, 1, 2, 8), 32'h200, 1, 32'h80000000, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_br", br_cnt, 32'd5);
    chk("t2_taken", taken_cnt, 32'd3);
    rst_step();
    step(mk(4, 3, 0, 1), 32'h40, 1, 7, 7, 3, 2, 0, 0, 0, 0);
    step(mk(4, 3, 0, 1), 32'h40, 1, 7, 7, 3, 2, 0, 0, 0, 0);
    chk("t3_stall_cnt", stall_cnt, 32'd2);
    chk("t3_br_held", br_cnt, 32'd0);
    step(mk(4, 3, 0, 1), 32'h40, 1, 7, 7, 3, 0, 0, 0, 0, 0);
    chk("t3_br", br_cnt, 32'd1);
    rst_step();
    for (int i = 0; i < 3; i++) step(mk(7, 5, 0, 2), 32'h80, 1, 1, 0, 0, 0, 5, 1, 0, 0);
    chk("t4_err_early", 32'(err_timeout), 32'h0);
    step(mk(7, 5, 0, 2), 32'h80, 1, 1, 0, 0, 0, 5, 1, 0, 0);
    chk("t4_err_set", 32'(err_timeout), 32'h1);
    for (int i = 0; i < 2; i++) step(mk(7, 5, 0, 2), 32'h80, 1, 1, 0, 0, 0, 5, 0, 0, 0);
    chk("t4_err_sticky", 32'(err_timeout), 32'h1);
    rst_step();
    chk("t4_err_clr", 32'(err_timeout), 32'h0);
    for (int i = 0; i < 3; i++) step(mk(5, 1, 2, 4), 32'hC0, 1, 1, 2, 0, 0, 0, 0, 1, 0);
    chk("t5_br_held", br_cnt, 32'd0);
    step(mk(5, 1, 2, 4), 32'hC0, 1, 1, 2, 0, 0, 0, 0, 0, 0);
    chk("t5_br", br_cnt, 32'd1);
    step(mk(1, 0, 0, 4), 32'hC0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    chk("t6_zero_reg", 32'(stall_D), 32'h0);
    step(mk(4, 4, 0, 4), 32'hC0, 1, 1, 0, 4, 1, 0, 0, 0, 0);
    step(mk(4, 4, 0, 4), 32'hC0, 1, 1, 0, 4, 1, 0, 0, 0, 0);
    step(mk(4, 4, 0, 4), 32'hC0, 1, 1, 0, 4, 1, 0, 0, 0, 1);
    chk("t6_rst_stall", stall_cnt, 32'd0);
    chk("t6_rst_br", br_cnt, 32'd0);
    for (int i = 0; i < 400; i++) begin
      int op;
      op = ops[$urandom_range(0, 8)];
      vals[6] = $urandom;
      step(mk(op, $urandom_range(0, 3), op == 1 ? $urandom_range(0, 2) : $urandom_range(0, 3), $urandom),
           $urandom, $urandom_range(0, 7) != 0, vals[$urandom_range(0, 6)], vals[$urandom_range(0, 6)],
           $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
           $urandom_range(0, 4) == 0, $urandom_range(0, 59) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/d_branch_ctrl.md
Name: d_branch_ctrl

Overview:
Decode-stage branch controller for the five-stage MIPS pipeline. It decodes the branch in D, holds the pipeline while a branch source register is still being produced in E or M, and resolves the comparison against the forwarded operands once they are ready. It drives the next-PC select and branch target, and keeps branch and stall statistics. Delayed-branch semantics apply: the delay slot is never flushed.

Parameters:
- MAX_WAIT, 3, number of consecutive hazard-stall cycles after which the sticky `err_timeout` is set.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- D_instr  in  32  instruction in D
- D_pc4  in  32  PC+4 of the D instruction
- D_valid  in  1  D instruction is valid (not a bubble)
- D_rs_val  in  32  forwarded rs value
- D_rt_val  in  32  forwarded rt value
- E_wa  in  5  destination register in E
- E_Tnew  in  2  cycles until the E result is available
- M_wa  in  5  destination register in M
- M_Tnew  in  2  cycles until the M result is available
- ext_stall  in  1  stall raised by another source (for example MDU busy)
- stall_D  out  1  freeze F/D and insert a bubble into E
- npc_sel  out  1  1 = take `branch_target` as the next PC
- branch_target  out  32  computed branch target
- err_timeout  out  1  sticky flag: hazard wait exceeded MAX_WAIT
- br_cnt  out  CNT_W  number of resolved branches
- taken_cnt  out  CNT_W  number of taken branches
- stall_cnt  out  CNT_W  number of branch-hazard stall cycles

Behaviour:
- Branch decode, from op = D_instr[31:26] and rt = D_instr[20:16]:
  - beq = 000100, bne = 000101, bgtz = 000111, blez = 000110.
  - bgez = op 000001 with rt 00001; bltz = op 000001 with rt 00000.
  - Any other op, or op 000001 with any other rt, is not a branch.
  - is_br = D_valid & decoded branch.
- Source registers:
  - rs is always used.
  - rt is used only by beq and bne.
  - Register $0 never causes a hazard.
- Hazard: haz = is_br & any used src != 0 & ((src == E_wa & E_Tnew != 0) | (src == M_wa & M_Tnew != 0)).
- stall_D = haz, combinational. It is independent of `ext_stall`.
- Compare, all signed 32-bit:
  - beq: rs == rt
  - bne: rs != rt
  - bgez: rs >= 0
  - bltz: rs < 0
  - bgtz: rs > 0
  - blez: rs <= 0
- Target: branch_target = D_pc4 + {sext(D_instr[15:0]), 2'b00}, combinational, computed even when there is no branch.
- Next-PC select: npc_sel = is_br & !haz & !ext_stall & cond. It is combinational with the same timing as `stall_D`.
- FSM, states IDLE and HOLD, with a wait counter `wcnt`:
  - IDLE, haz = 1: go to HOLD, wcnt <= 1.
  - IDLE, otherwise: stay in IDLE.
  - HOLD, haz = 1: stay in HOLD, wcnt <= wcnt + 1, saturating at MAX_WAIT+1.
  - HOLD, haz = 0: go to IDLE, wcnt <= 0.
  - When the next value of wcnt is greater than MAX_WAIT, set `err_timeout`. It is cleared only by reset.
  - If D_valid drops during HOLD, haz becomes 0 and the FSM returns to IDLE.
- Statistics, evaluated on the clock edge, all wrapping modulo 2^CNT_W:
  - stall_cnt += 1 in every cycle where haz = 1.
  - br_cnt += 1 in every cycle where is_br & !haz & !ext_stall (a resolve event).
  - taken_cnt += 1 in every cycle where npc_sel = 1.
  - Each branch is counted once: after a resolve the D stage advances, so a held instruction is not re-counted.
  - ext_stall = 1 suppresses resolve events, so the branch is resolved in the first cycle with ext_stall = 0.
- Reset (synchronous, highest priority, including mid-HOLD):
  - state <= IDLE, wcnt <= 0, err_timeout <= 0, all counters <= 0.
  - stall_D and npc_sel are combinational and still follow their inputs during reset.

Test Plan:
1. beq $1,$2 with D_rs_val = D_rt_val = 5, no hazard, imm = 0x0003, D_pc4 = 0x3004 -> npc_sel = 1, branch_target = 0x3010, br_cnt = 1, taken_cnt = 1.
2. bne rs = rt = 0xFFFFFFFF -> npc_sel = 0; bltz with rs = 0x80000000 -> npc_sel = 1; blez with rs = 0 -> 1; bgtz with rs = 0 -> 0; op 000001 with rt = 00010 -> is_br = 0 and no counters change.
3. beq rs = $3 with E_wa = 3, E_Tnew = 2 for 2 cycles, then cleared -> stall_D = 1 for 2 cycles, stall_cnt = 2, FSM returns to IDLE, resolve happens on the 3rd cycle.
4. Hazard held for 4 cycles with MAX_WAIT = 3 -> err_timeout rises on the 4th edge and stays high after the hazard clears, until reset.
5. Branch with no hazard and ext_stall = 1 for 3 cycles -> npc_sel = 0 and br_cnt unchanged during those cycles; br_cnt increments by exactly 1 in the cycle ext_stall falls.
6. Hazard on $0 (E_wa = 0, E_Tnew = 2, rs = 0) -> stall_D = 0. Reset asserted during HOLD -> next state IDLE, with all counters and err_timeout reading 0.
